// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg
// Shared types and constants for the SD drive arbiter.
//   arb_state_e : arbiter FSM states
//   arb_op_e    : latched host operation (read or write)
//   rr_next()   : round-robin pointer advance with wrap at the drive count
package sd_arb_pkg;

   localparam int LBA_W   = 32;
   localparam int BLK_W   = 6;
   localparam int MAX_DRV = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } arb_state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } arb_op_e;

   function automatic logic [1:0] rr_next(input logic [1:0] g, input int ndr);
      if (int'(g) + 1 >= ndr) begin
         return 2'd0;
      end
      return g + 2'd1;
   endfunction

endpackage

// File: rtl/sd_arb_rr_pick.sv
// sd_arb_rr_pick
// Combinational round-robin selector: returns the first pending drive found
// when searching upward from rr_i, modulo NDR.
// Ports:
//   pend_i  [MAX_DRV]  per-drive pending flags (bits >= NDR are ignored)
//   rr_i    [2]        search start index (always < NDR)
//   valid_o [1]        at least one drive pending
//   idx_o   [2]        selected drive index
module sd_arb_rr_pick
   import sd_arb_pkg::*;
#(
   parameter int NDR = 2
) (
   input  logic [MAX_DRV-1:0] pend_i,
   input  logic [1:0]         rr_i,
   output logic               valid_o,
   output logic [1:0]         idx_o
);

   int j;

   // Walk the offsets from farthest to nearest so the nearest pending drive
   // is the last one assigned and therefore wins.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = 2'd0;
      j       = 0;
      for (int k = NDR - 1; k >= 0; k--) begin
         j = int'(rr_i) + k;
         if (j >= NDR) begin
            j = j - NDR;
         end
         if (pend_i[j]) begin
            valid_o = 1'b1;
            idx_o   = 2'(j);
         end
      end
   end

endmodule

// File: rtl/sd_drive_arbiter.sv
// sd_drive_arbiter
// Shares one host SD block interface between NDR drive instances, granting
// one drive at a time in round-robin order. The granted drive's LBA and block
// count are latched and presented to the host; host ack and write data are
// routed to/from the granted drive only.
//
// Ports:
//   clk_sys, reset          clock, synchronous active-high reset
//   drv_lba/drv_blk_cnt     per-drive address and block count (packed, NDR wide)
//   drv_rd/drv_wr           per-drive level requests, held until ack
//   drv_ack                 per-drive ack, only the granted drive sees sd_ack
//   drv_buff_din            per-drive write data
//   sd_lba/sd_blk_cnt       latched address/count to host
//   sd_rd/sd_wr             host request strobes (registered)
//   sd_ack                  host acknowledge, high for the whole transfer
//   sd_buff_din             write data of the granted drive
//   grant                   current or last granted drive
//   busy                    FSM not in IDLE
//   timeout_err             one-cycle pulse when a request is aborted
//
// Build option: define SD_ARB_TIMEOUT_EN to abort a host request that is not
// acknowledged within 2**TO_W-1 REQ cycles. Without it, REQ waits forever and
// timeout_err is tied low.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no grant; pick next pending drive from rr and latch it
// REQ   | host request asserted, waiting for sd_ack
// XFER  | transfer running, sd_ack mirrored to the granted drive
// DONE  | one cycle; advance rr past the granted drive
module sd_drive_arbiter
   import sd_arb_pkg::*;
#(
   parameter int NDR  = 2,
   parameter int TO_W = 24
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic [NDR*LBA_W-1:0]   drv_lba,
   input  logic [NDR*BLK_W-1:0]   drv_blk_cnt,
   input  logic [NDR-1:0]         drv_rd,
   input  logic [NDR-1:0]         drv_wr,
   output logic [NDR-1:0]         drv_ack,
   input  logic [NDR*8-1:0]       drv_buff_din,
   output logic [LBA_W-1:0]       sd_lba,
   output logic [BLK_W-1:0]       sd_blk_cnt,
   output logic                   sd_rd,
   output logic                   sd_wr,
   input  logic                   sd_ack,
   output logic [7:0]             sd_buff_din,
   output logic [1:0]             grant,
   output logic                   busy,
   output logic                   timeout_err
);

   if (NDR < 1 || NDR > MAX_DRV) begin : g_bad_ndr
      $error("sd_drive_arbiter: NDR must be 1..4");
   end
   if (TO_W < 2) begin : g_bad_to_w
      $error("sd_drive_arbiter: TO_W must be at least 2");
   end

   // Widen the per-drive inputs to MAX_DRV slots so every index below is a
   // plain 2-bit select, whatever NDR is.
   logic [MAX_DRV-1:0] pend_pad;
   logic [MAX_DRV-1:0] wr_pad;
   logic [LBA_W-1:0]   lba_a [MAX_DRV];
   logic [BLK_W-1:0]   blk_a [MAX_DRV];
   logic [7:0]         din_a [MAX_DRV];

   for (genvar i = 0; i < MAX_DRV; i++) begin : g_pad
      if (i < NDR) begin : g_on
         assign pend_pad[i] = drv_rd[i] | drv_wr[i];
         assign wr_pad[i]   = drv_wr[i];
         assign lba_a[i]    = drv_lba[i*LBA_W +: LBA_W];
         assign blk_a[i]    = drv_blk_cnt[i*BLK_W +: BLK_W];
         assign din_a[i]    = drv_buff_din[i*8 +: 8];
      end else begin : g_off
         assign pend_pad[i] = 1'b0;
         assign wr_pad[i]   = 1'b0;
         assign lba_a[i]    = '0;
         assign blk_a[i]    = '0;
         assign din_a[i]    = '0;
      end
   end

   arb_state_e       state_q;
   arb_op_e          op_q;
   logic [1:0]       grant_q;
   logic [1:0]       rr_q;
   logic [LBA_W-1:0] lba_q;
   logic [BLK_W-1:0] blk_q;
   logic             sd_rd_q;
   logic             sd_wr_q;
   logic             timeout_q;
`ifdef SD_ARB_TIMEOUT_EN
   logic [TO_W-1:0]  cnt_q;
`endif

   logic       pick_valid;
   logic [1:0] pick_idx;

   sd_arb_rr_pick #(
      .NDR (NDR)
   ) u_pick (
      .pend_i  (pend_pad),
      .rr_i    (rr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= OP_RD;
         grant_q   <= 2'd0;
         rr_q      <= 2'd0;
         lba_q     <= '0;
         blk_q     <= '0;
         sd_rd_q   <= 1'b0;
         sd_wr_q   <= 1'b0;
         timeout_q <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  grant_q <= pick_idx;
                  lba_q   <= lba_a[pick_idx];
                  blk_q   <= blk_a[pick_idx];
                  op_q    <= wr_pad[pick_idx] ? OP_WR : OP_RD;
                  state_q <= REQ;
`ifdef SD_ARB_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            // The host request is not withdrawn if the drive drops its
            // request here; the host has already been asked.
            REQ: begin
               if (sd_ack) begin
                  sd_rd_q <= 1'b0;
                  sd_wr_q <= 1'b0;
                  state_q <= XFER;
               end
`ifdef SD_ARB_TIMEOUT_EN
               else if (&cnt_q) begin
                  sd_rd_q   <= 1'b0;
                  sd_wr_q   <= 1'b0;
                  timeout_q <= 1'b1;
                  state_q   <= DONE;
               end
`endif
               else begin
                  sd_rd_q <= (op_q == OP_RD);
                  sd_wr_q <= (op_q == OP_WR);
`ifdef SD_ARB_TIMEOUT_EN
                  cnt_q   <= cnt_q + 1'b1;
`endif
               end
            end
            XFER: begin
               if (!sd_ack) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               rr_q    <= rr_next(grant_q, NDR);
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Ack is also passed through in REQ so the drive sees the very first ack
   // cycle; the FSM moves to XFER on that same edge.
   logic [MAX_DRV-1:0] ack_pad;

   always_comb begin
      ack_pad = '0;
      if ((state_q == REQ || state_q == XFER) && sd_ack) begin
         ack_pad[grant_q] = 1'b1;
      end
   end

   assign drv_ack     = ack_pad[NDR-1:0];
   assign sd_lba      = lba_q;
   assign sd_blk_cnt  = blk_q;
   assign sd_rd       = sd_rd_q;
   assign sd_wr       = sd_wr_q;
   assign sd_buff_din = din_a[grant_q];
   assign grant       = grant_q;
   assign busy        = (state_q != IDLE);
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_sd_drive_arbiter.sv
module tb_sd_drive_arbiter;

   localparam int NDR = 4;
`ifdef SD_ARB_TIMEOUT_EN
   localparam int TO_W = 4;
`else
   localparam int TO_W = 24;
`endif

   logic              clk_sys = 1'b0;
   logic              reset;
   logic [NDR*32-1:0] drv_lba;
   logic [NDR*6-1:0]  drv_blk_cnt;
   logic [NDR-1:0]    drv_rd;
   logic [NDR-1:0]    drv_wr;
   logic [NDR-1:0]    drv_ack;
   logic [NDR*8-1:0]  drv_buff_din;
   logic [31:0]       sd_lba;
   logic [5:0]        sd_blk_cnt;
   logic              sd_rd;
   logic              sd_wr;
   logic              sd_ack;
   logic [7:0]        sd_buff_din;
   logic [1:0]        grant;
   logic              busy;
   logic              timeout_err;

   sd_drive_arbiter #(
      .NDR  (NDR),
      .TO_W (TO_W)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .drv_lba      (drv_lba),
      .drv_blk_cnt  (drv_blk_cnt),
      .drv_rd       (drv_rd),
      .drv_wr       (drv_wr),
      .drv_ack      (drv_ack),
      .drv_buff_din (drv_buff_din),
      .sd_lba       (sd_lba),
      .sd_blk_cnt   (sd_blk_cnt),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .sd_ack       (sd_ack),
      .sd_buff_din  (sd_buff_din),
      .grant        (grant),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;

   logic [31:0] lba_tab [4];
   logic [5:0]  blk_tab [4];
   logic [7:0]  din_tab [4];

   typedef struct {
      logic [3:0] rd;
      logic [3:0] wr;
      logic       ack;
      logic       e_rd;
      logic       e_wr;
      logic [3:0] e_ack;
      logic       e_busy;
      logic [1:0] e_grant;
   } vec_t;

   vec_t vt [22];

   function automatic vec_t mk(input logic [3:0] rd, input logic [3:0] wr, input logic ack,
                               input logic e_rd, input logic e_wr, input logic [3:0] e_ack,
                               input logic e_busy, input logic [1:0] e_grant);
      vec_t v;
      v.rd = rd; v.wr = wr; v.ack = ack;
      v.e_rd = e_rd; v.e_wr = e_wr; v.e_ack = e_ack;
      v.e_busy = e_busy; v.e_grant = e_grant;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset;
      reset  = 1'b1;
      drv_rd = '0;
      drv_wr = '0;
      sd_ack = 1'b0;
      step;
      step;
      reset = 1'b0;
   endtask

   task automatic wait_req(input string tag, output bit ok);
      int n;
      n = 0;
      while (!(sd_rd || sd_wr) && n < 20) begin
         step;
         n++;
      end
      ok = sd_rd || sd_wr;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: no host request within 20 cycles", tag);
      end
   endtask

   // Completes one host transfer for drive g; ends with the arbiter in DONE.
   task automatic serve(input int g, input logic exp_wr);
      bit         ok;
      logic [3:0] oh;
      oh = 4'b0001 << g;
      wait_req($sformatf("serve_wait_d%0d", g), ok);
      if (!ok) return;
      chk($sformatf("serve_grant_d%0d", g), 32'(grant), 32'(g));
      chk($sformatf("serve_lba_d%0d", g), sd_lba, lba_tab[g]);
      chk($sformatf("serve_blk_d%0d", g), 32'(sd_blk_cnt), 32'(blk_tab[g]));
      chk($sformatf("serve_wr_d%0d", g), 32'(sd_wr), 32'(exp_wr));
      chk($sformatf("serve_rd_d%0d", g), 32'(sd_rd), 32'(!exp_wr));
      sd_ack = 1'b1;
      step;
      chk($sformatf("serve_ack1_d%0d", g), 32'(drv_ack), 32'(oh));
      drv_rd[g] = 1'b0;
      drv_wr[g] = 1'b0;
      step;
      chk($sformatf("serve_ack2_d%0d", g), 32'(drv_ack), 32'(oh));
      sd_ack = 1'b0;
      step;
      chk($sformatf("serve_ack_off_d%0d", g), 32'(drv_ack), 32'd0);
      chk($sformatf("serve_done_busy_d%0d", g), 32'(busy), 32'd1);
   endtask

   initial begin
      bit ok;
      int hi;
      int pulses;

      lba_tab = '{32'h0000_0123, 32'hDEAD_BEEF, 32'h2222_0002, 32'h3333_0003};
      blk_tab = '{6'd0, 6'd5, 6'h2A, 6'h3F};
      din_tab = '{8'h5A, 8'hA5, 8'h33, 8'hC3};
      drv_lba      = {lba_tab[3], lba_tab[2], lba_tab[1], lba_tab[0]};
      drv_blk_cnt  = {blk_tab[3], blk_tab[2], blk_tab[1], blk_tab[0]};
      drv_buff_din = {din_tab[3], din_tab[2], din_tab[1], din_tab[0]};

      // single read from drive 0, 10-cycle ack
      vt[0]  = mk(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0);
      vt[1]  = mk(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0);
      vt[2]  = mk(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0);
      for (int i = 3; i <= 11; i++) begin
         vt[i] = mk(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0);
      end
      vt[12] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0);
      vt[13] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
      // drive 1 with rd and wr both set: write wins
      vt[14] = mk(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1);
      vt[15] = mk(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1);
      vt[16] = mk(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1);
      vt[17] = mk(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1);
      vt[18] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1);
      vt[19] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1);
      // spurious host ack while idle
      vt[20] = mk(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1);
      vt[21] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1);

      // reset values
      reset  = 1'b1;
      drv_rd = '0;
      drv_wr = '0;
      sd_ack = 1'b0;
      step;
      step;
      chk("rst_sd_rd", 32'(sd_rd), 32'd0);
      chk("rst_sd_wr", 32'(sd_wr), 32'd0);
      chk("rst_drv_ack", 32'(drv_ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_timeout", 32'(timeout_err), 32'd0);
      chk("rst_lba", sd_lba, 32'd0);
      chk("rst_blk", 32'(sd_blk_cnt), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 22; i++) begin
         drv_rd = vt[i].rd;
         drv_wr = vt[i].wr;
         sd_ack = vt[i].ack;
         step;
         chk($sformatf("vec%0d_sd_rd", i), 32'(sd_rd), 32'(vt[i].e_rd));
         chk($sformatf("vec%0d_sd_wr", i), 32'(sd_wr), 32'(vt[i].e_wr));
         chk($sformatf("vec%0d_drv_ack", i), 32'(drv_ack), 32'(vt[i].e_ack));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
         chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vt[i].e_grant));
         chk($sformatf("vec%0d_lba", i), sd_lba, lba_tab[vt[i].e_grant]);
         chk($sformatf("vec%0d_blk", i), 32'(sd_blk_cnt), 32'(blk_tab[vt[i].e_grant]));
         chk($sformatf("vec%0d_buff", i), 32'(sd_buff_din), 32'(din_tab[vt[i].e_grant]));
         chk($sformatf("vec%0d_timeout", i), 32'(timeout_err), 32'd0);
      end

      // all four drives request from reset: served 0,1,2,3
      do_reset;
      drv_rd = 4'b1111;
      for (int g = 0; g < 4; g++) begin
         serve(g, 1'b0);
      end
      step;

      // reset during XFER with host ack high
      do_reset;
      drv_rd = 4'b0100;
      wait_req("rst_xfer_wait", ok);
      sd_ack = 1'b1;
      step;
      chk("rst_xfer_pre_grant", 32'(grant), 32'd2);
      chk("rst_xfer_pre_ack", 32'(drv_ack), 32'b0100);
      drv_rd = '0;
      reset  = 1'b1;
      step;
      chk("rst_xfer_sd_rd", 32'(sd_rd), 32'd0);
      chk("rst_xfer_drv_ack", 32'(drv_ack), 32'd0);
      chk("rst_xfer_busy", 32'(busy), 32'd0);
      chk("rst_xfer_grant", 32'(grant), 32'd0);
      chk("rst_xfer_lba", sd_lba, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step;
         chk($sformatf("rst_xfer_late_ack%0d", i), 32'(drv_ack), 32'd0);
         chk($sformatf("rst_xfer_late_busy%0d", i), 32'(busy), 32'd0);
      end
      sd_ack = 1'b0;

      // drive 0 re-requests immediately; drive 1 already pending goes first
      do_reset;
      drv_rd = 4'b0011;
      serve(0, 1'b0);
      drv_rd[0] = 1'b1;
      serve(1, 1'b0);
      serve(0, 1'b0);
      step;

      // unacknowledged host request
      do_reset;
      drv_rd = 4'b0011;
      hi     = 0;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         step;
         if (sd_rd && grant == 2'd0) hi++;
         if (timeout_err) pulses++;
      end
`ifdef SD_ARB_TIMEOUT_EN
      chk("to_req_cycles", 32'(hi), 32'd15);
      chk("to_pulses", 32'(pulses), 32'd1);
      chk("to_next_grant", 32'(grant), 32'd1);
      chk("to_next_sd_rd", 32'(sd_rd), 32'd1);
`else
      chk("nto_req_cycles", 32'(hi), 32'd29);
      chk("nto_pulses", 32'(pulses), 32'd0);
      chk("nto_grant", 32'(grant), 32'd0);
      chk("nto_sd_rd", 32'(sd_rd), 32'd1);
`endif
      do_reset;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
